mem_arbiter: RTL and testbench

Shares the single DDR3 user-interface command port between the cartridge requester (GBA bus reads/writes of ROM/SRAM image) and the USB requester (FX3 bulk image upload/readback). It sits between `mux` and `mem` in the `ui_clk` domain, grants the cartridge strict priority with a bounded starvation guard for USB, and routes in-order read data back to the requester that issued each read.

---
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the DDR3 UI command port between cart (priority) and USB requesters,
// with a starvation guard for USB and in-order read-data routing via a tag FIFO.
module mem_arbiter #(
  parameter int ADDR_W          = 28,
  parameter int DATA_W          = 128,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_init_done,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              u_req,
  input  logic              u_we,
  input  logic [ADDR_W-1:0] u_addr,
  input  logic [DATA_W-1:0] u_wdata,
  output logic              u_gnt,
  output logic              u_rvalid,
  output logic [DATA_W-1:0] u_rdata,
  output logic              m_cmd_valid,
  output logic              m_cmd_we,
  output logic [ADDR_W-1:0] m_cmd_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_cmd_ready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err_rd_underflow
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_OUTSTANDING);
  localparam logic [ST_W-1:0]  STARVE_MAX = ST_W'(STARVE_LIMIT);

  typedef enum logic {S_IDLE, S_CMD} state_t;

  state_t state_q, state_d;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              owner_q, owner_d;   // 1 = USB owns the staged command

  logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [ST_W-1:0]            starve_q, starve_d;

  logic              c_rvalid_q, c_rvalid_d;
  logic              u_rvalid_q, u_rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic sel_usb, sel_valid, sel_we, stage, hs, push, pop;

  // Selection and handshake qualifiers shared by the FSM and datapath
  always_comb begin
    sel_usb   = u_req && (!c_req || (starve_q == STARVE_MAX));
    sel_valid = c_req || u_req;
    sel_we    = sel_usb ? u_we : c_we;
    stage     = (state_q == S_IDLE) && m_init_done && sel_valid &&
                (sel_we || (cnt_q < MAX_CNT));
    hs        = (state_q == S_CMD) && m_cmd_ready;
    push      = hs && !we_q;
    pop       = m_rvalid && (cnt_q != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (stage)       state_d = S_CMD;
      S_CMD:  if (m_cmd_ready) state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_cmd_valid      = (state_q == S_CMD);
    m_cmd_we         = we_q;
    m_cmd_addr       = addr_q;
    m_wdata          = wdata_q;
    c_gnt            = hs && !owner_q;
    u_gnt            = hs && owner_q;
    c_rvalid         = c_rvalid_q;
    u_rvalid         = u_rvalid_q;
    c_rdata          = rdata_q;
    u_rdata          = rdata_q;
    err_rd_underflow = err_q;
  end

  always_comb begin
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    owner_d  = owner_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    if (stage) begin
      owner_d = sel_usb;
      we_d    = sel_we;
      addr_d  = sel_usb ? u_addr : c_addr;
      wdata_d = sel_usb ? u_wdata : c_wdata;
    end

    if (push) begin
      tag_d[wr_ptr_q] = owner_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      rdata_d  = m_rdata;
    end
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);

    c_rvalid_d = pop && !tag_q[rd_ptr_q];
    u_rvalid_d = pop && tag_q[rd_ptr_q];

    if (m_rvalid && (cnt_q == '0)) err_d = 1'b1;

    // USB waiting is what the guard measures, so u_req low always wins
    if (!u_req || u_gnt)                      starve_d = '0;
    else if (c_gnt && starve_q != STARVE_MAX) starve_d = starve_q + ST_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      owner_q    <= 1'b0;
      tag_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      starve_q   <= '0;
      c_rvalid_q <= 1'b0;
      u_rvalid_q <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      owner_q    <= owner_d;
      tag_q      <= tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      c_rvalid_q <= c_rvalid_d;
      u_rvalid_q <= u_rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected grants and
// read returns; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         m_init_done = 1'b0;
  logic         c_req = 1'b0, c_we = 1'b0;
  logic [27:0]  c_addr = '0;
  logic [127:0] c_wdata = '0;
  logic         u_req = 1'b0, u_we = 1'b0;
  logic [27:0]  u_addr = '0;
  logic [127:0] u_wdata = '0;
  logic         c_gnt, c_rvalid, u_gnt, u_rvalid;
  logic [127:0] c_rdata, u_rdata;
  logic         m_cmd_valid, m_cmd_we;
  logic [27:0]  m_cmd_addr;
  logic [127:0] m_wdata;
  logic         m_cmd_ready = 1'b1;
  logic         m_rvalid = 1'b0;
  logic [127:0] m_rdata = '0;
  logic         err_rd_underflow;

  mem_arbiter #(.ADDR_W(28), .DATA_W(128), .MAX_OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .m_init_done(m_init_done),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .u_req(u_req), .u_we(u_we), .u_addr(u_addr), .u_wdata(u_wdata),
    .u_gnt(u_gnt), .u_rvalid(u_rvalid), .u_rdata(u_rdata),
    .m_cmd_valid(m_cmd_valid), .m_cmd_we(m_cmd_we), .m_cmd_addr(m_cmd_addr),
    .m_wdata(m_wdata), .m_cmd_ready(m_cmd_ready), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .err_rd_underflow(err_rd_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           owner;
    bit           we;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } gnt_exp_t;

  typedef struct {
    bit           owner;
    logic [127:0] data;
  } rd_exp_t;

  gnt_exp_t exp_gnt[$];
  rd_exp_t  exp_rd[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every grant and every read-data pulse must match the head of its queue
  always @(negedge clk) begin
    if (rst) begin
      if (c_gnt || u_gnt) begin
        chk("gnt_onehot", {c_gnt, u_gnt} != 2'b11, 1'b1);
        if (exp_gnt.size() == 0) chk("unexpected_gnt", {c_gnt, u_gnt}, 2'b00);
        else begin
          gnt_exp_t g;
          g = exp_gnt.pop_front();
          chk("gnt_owner", u_gnt, g.owner);
          chk("cmd_we", m_cmd_we, g.we);
          chk("cmd_addr", m_cmd_addr, g.addr);
          if (g.we) chk("cmd_wdata", m_wdata, g.wdata);
        end
      end
      if (c_rvalid || u_rvalid) begin
        chk("rvalid_onehot", {c_rvalid, u_rvalid} != 2'b11, 1'b1);
        if (exp_rd.size() == 0) chk("unexpected_rvalid", {c_rvalid, u_rvalid}, 2'b00);
        else begin
          rd_exp_t r;
          r = exp_rd.pop_front();
          chk("rd_owner", u_rvalid, r.owner);
          chk("rd_data", u_rvalid ? u_rdata : c_rdata, r.data);
        end
      end
    end
  end

  task automatic set_req(input bit owner, input bit we, input logic [27:0] addr,
                         input logic [127:0] wdata);
    if (owner) begin u_we = we; u_addr = addr; u_wdata = wdata; u_req = 1'b1; end
    else       begin c_we = we; c_addr = addr; c_wdata = wdata; c_req = 1'b1; end
  endtask

  // Issue one request and hold it until granted. Optionally return a read beat in
  // the grant cycle so that push and pop land on the same edge.
  task automatic do_req(input bit owner, input bit we, input logic [27:0] addr,
                        input logic [127:0] wdata, input bit push_rd,
                        input logic [127:0] rdata, input bit ret_now,
                        input logic [127:0] ret_data, output int waited);
    bit got = 1'b0;
    exp_gnt.push_back('{owner, we, addr, wdata});
    if (!we && push_rd) exp_rd.push_back('{owner, rdata});
    set_req(owner, we, addr, wdata);
    waited = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      waited++;
      if (owner ? u_gnt : c_gnt) begin got = 1'b1; break; end
    end
    if (!got) chk("gnt_timeout", 1'b0, 1'b1);
    if (ret_now) begin m_rvalid = 1'b1; m_rdata = ret_data; end
    @(posedge clk); #1;
    if (owner) u_req = 1'b0; else c_req = 1'b0;
    m_rvalid = 1'b0;
  endtask

  task automatic pulse_rd(input logic [127:0] d);
    m_rvalid = 1'b1; m_rdata = d;
    @(posedge clk); #1;
    m_rvalid = 1'b0;
  endtask

  task automatic wait_cmd_valid();
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_cmd_valid) begin seen = 1'b1; break; end
    end
    chk("cmd_valid_timeout", seen, 1'b1);
  endtask

  function automatic logic [127:0] pat(input logic [7:0] b);
    return {16{b}};
  endfunction

  initial begin
    int w, n;
    logic [27:0]  sa;
    logic [127:0] sd;
    logic         sw;
    #1;
    #20;
    chk("rst_outputs",
        {m_cmd_valid, c_gnt, u_gnt, c_rvalid, u_rvalid, m_cmd_we, err_rd_underflow}, 7'd0);
    chk("rst_bus", {m_cmd_addr, m_wdata, c_rdata, u_rdata} == '0, 1'b1);
    rst = 1'b1;
    m_init_done = 1'b1;
    @(posedge clk); #1;

    // Single cart read
    do_req(1'b0, 1'b0, 28'h0000100, '0, 1'b1, pat(8'hA5), 1'b0, '0, w);
    chk("gnt_latency", w, 2);
    repeat (4) @(posedge clk);
    #1;
    pulse_rd(pat(8'hA5));
    @(negedge clk);
    chk("rvalid_latency", {c_rvalid, u_rvalid}, 2'b10);

    // Starvation guard: both held, writes, 8 cart then 1 USB, twice
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 8; j++) exp_gnt.push_back('{1'b0, 1'b1, 28'h0000200, pat(8'h11)});
      exp_gnt.push_back('{1'b1, 1'b1, 28'h0000300, pat(8'h22)});
    end
    set_req(1'b0, 1'b1, 28'h0000200, pat(8'h11));
    set_req(1'b1, 1'b1, 28'h0000300, pat(8'h22));
    n = 0;
    for (int i = 0; i < 100 && n < 18; i++) begin
      @(negedge clk);
      if (c_gnt || u_gnt) n++;
    end
    chk("starve_grants", n, 18);
    @(posedge clk); #1;
    c_req = 1'b0; u_req = 1'b0;

    // Interleaved reads with returns overlapping later grants
    do_req(1'b0, 1'b0, 28'h0001000, '0, 1'b1, pat(8'hC0), 1'b0, '0, w);
    do_req(1'b1, 1'b0, 28'h0002000, '0, 1'b1, pat(8'hD1), 1'b1, pat(8'hC0), w);
    do_req(1'b0, 1'b0, 28'h0001010, '0, 1'b1, pat(8'hC2), 1'b1, pat(8'hD1), w);
    do_req(1'b1, 1'b0, 28'h0002010, '0, 1'b1, pat(8'hD3), 1'b1, pat(8'hC2), w);
    pulse_rd(pat(8'hD3));
    repeat (2) @(negedge clk);
    chk("no_underflow_after_interleave", err_rd_underflow, 1'b0);
    @(posedge clk); #1;

    // Tracker full: fifth read stalls until one beat returns
    for (int j = 0; j < 4; j++)
      do_req(1'b0, 1'b0, 28'h0003000 + 28'(j * 16), '0, 1'b1, pat(8'hE0 + 8'(j)), 1'b0, '0, w);
    exp_gnt.push_back('{1'b0, 1'b0, 28'h0003040, '0});
    exp_rd.push_back('{1'b0, pat(8'hE4)});
    set_req(1'b0, 1'b0, 28'h0003040, '0);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_cmd_valid || c_gnt) n++;
    end
    chk("full_stall", n, 0);
    @(posedge clk); #1;
    pulse_rd(pat(8'hE0));
    @(negedge clk);
    chk("stall_release_idle", m_cmd_valid, 1'b0);
    @(negedge clk);
    chk("stall_release_cmd", {m_cmd_valid, c_gnt}, 2'b11);
    @(posedge clk); #1;
    c_req = 1'b0;
    for (int j = 1; j < 5; j++) pulse_rd(pat(8'hE0 + 8'(j)));

    // Backpressure on a USB write, then init_done low blocks new staging
    m_cmd_ready = 1'b0;
    exp_gnt.push_back('{1'b1, 1'b1, 28'h0004000, pat(8'h5A)});
    set_req(1'b1, 1'b1, 28'h0004000, pat(8'h5A));
    wait_cmd_valid();
    sa = m_cmd_addr; sd = m_wdata; sw = m_cmd_we;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) m_init_done = 1'b0;
      if (!m_cmd_valid || u_gnt || c_gnt || m_cmd_addr !== sa || m_wdata !== sd || m_cmd_we !== sw)
        n++;
    end
    chk("backpressure_stable", n, 0);
    chk("backpressure_addr", sa, 28'h0004000);
    @(posedge clk); #1;
    m_cmd_ready = 1'b1;
    @(negedge clk);
    chk("u_gnt_on_ready", u_gnt, 1'b1);
    @(posedge clk); #1;
    u_req = 1'b0;
    set_req(1'b0, 1'b1, 28'h0005000, pat(8'h77));
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (m_cmd_valid || c_gnt) n++;
    end
    chk("init_done_blocks", n, 0);
    @(posedge clk); #1;
    c_req = 1'b0;
    m_init_done = 1'b1;

    // Reset mid-CMD with two reads outstanding
    do_req(1'b0, 1'b0, 28'h0006000, '0, 1'b0, '0, 1'b0, '0, w);
    do_req(1'b0, 1'b0, 28'h0006010, '0, 1'b0, '0, 1'b0, '0, w);
    m_cmd_ready = 1'b0;
    set_req(1'b0, 1'b0, 28'h0006020, '0);
    wait_cmd_valid();
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("midrst_outputs",
        {m_cmd_valid, c_gnt, u_gnt, c_rvalid, u_rvalid, m_cmd_we, err_rd_underflow}, 7'd0);
    chk("midrst_bus", {m_cmd_addr, m_wdata, c_rdata, u_rdata} == '0, 1'b1);
    c_req = 1'b0;
    m_cmd_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("err_clear_after_rst", err_rd_underflow, 1'b0);
    @(posedge clk); #1;
    pulse_rd(pat(8'h99));
    @(negedge clk);
    chk("stray_err", err_rd_underflow, 1'b1);
    chk("stray_no_rvalid", {c_rvalid, u_rvalid}, 2'b00);
    repeat (3) @(negedge clk);
    chk("err_sticky", err_rd_underflow, 1'b1);

    chk("gnt_queue_drained", exp_gnt.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
